// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC barrel shifter slice.
// Holds the default width, shift-width helper and per-beat control flags.
package cordic_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Shift-amount width for a given data width (at least one bit).
    function automatic int sh_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Control flags that travel with every beat.
    typedef struct packed {
        logic arith;
        logic rnd;
        logic g;
    } ctl_t;

endpackage

// File: rtl/cordic_bshift_stage.sv
// One elastic pipeline stage: conditional right shift by DIST plus guard update.
// Ports: in_* upstream beat and ready, out_* registered beat and downstream ready.
module cordic_bshift_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIST = 1,
    localparam int SHW = sh_width(WIDTH),
    localparam int K = $clog2(DIST)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_sh,
    input  logic             in_arith,
    input  logic             in_rnd,
    input  logic             in_g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_sh,
    output logic             out_arith,
    output logic             out_rnd,
    output logic             out_g
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   sh;
        ctl_t             ctl;
    } stage_t;

    stage_t           st_q, st_d;
    logic [WIDTH-1:0] sra, srl, shifted;

    // Kept as separate assignments so the signed shift is not
    // turned unsigned by the surrounding conditional.
    assign sra     = $signed(in_data) >>> DIST;
    assign srl     = in_data >> DIST;
    assign shifted = in_arith ? sra : srl;

    assign in_ready = !st_q.valid | out_ready;

    always_comb begin
        st_d = st_q;
        if (in_ready) begin
            st_d.valid = in_valid;
            if (in_valid) begin
                st_d.data      = in_sh[K] ? shifted : in_data;
                st_d.sh        = in_sh;
                st_d.ctl.arith = in_arith;
                st_d.ctl.rnd   = in_rnd;
                // Guard is the last bit pushed out by this stage.
                st_d.ctl.g     = in_sh[K] ? in_data[DIST-1] : in_g;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign out_valid = st_q.valid;
    assign out_data  = st_q.data;
    assign out_sh    = st_q.sh;
    assign out_arith = st_q.ctl.arith;
    assign out_rnd   = st_q.ctl.rnd;
    assign out_g     = st_q.ctl.g;

endmodule

// File: rtl/cordic_bshift.sv
// Pipelined right barrel shifter with arithmetic/logical fill and round-half-up.
// Ports: in_valid/in_ready/a/sh/arith/rnd upstream, out_valid/out_ready/dataout downstream.
module cordic_bshift
    import cordic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int SHW = sh_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   sh,
    input  logic             arith,
    input  logic             rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout
);

    logic             v_w   [SHW+1];
    logic             rdy_w [SHW+1];
    logic [WIDTH-1:0] d_w   [SHW+1];
    logic [SHW-1:0]   sh_w  [SHW+1];
    logic             ar_w  [SHW+1];
    logic             rn_w  [SHW+1];
    logic             g_w   [SHW+1];

    assign v_w[0]   = in_valid;
    assign d_w[0]   = a;
    assign sh_w[0]  = sh;
    assign ar_w[0]  = arith;
    assign rn_w[0]  = rnd;
    assign g_w[0]   = 1'b0;
    assign in_ready = rdy_w[0];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        cordic_bshift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (v_w[k]),
            .in_ready  (rdy_w[k]),
            .in_data   (d_w[k]),
            .in_sh     (sh_w[k]),
            .in_arith  (ar_w[k]),
            .in_rnd    (rn_w[k]),
            .in_g      (g_w[k]),
            .out_valid (v_w[k+1]),
            .out_ready (rdy_w[k+1]),
            .out_data  (d_w[k+1]),
            .out_sh    (sh_w[k+1]),
            .out_arith (ar_w[k+1]),
            .out_rnd   (rn_w[k+1]),
            .out_g     (g_w[k+1])
        );
    end

    // Shift amount and fill mode are fully consumed by the shift stages.
    logic unused_tail;
    assign unused_tail = ^{sh_w[SHW], ar_w[SHW]};

    logic             sr_valid_q, sr_valid_d;
    logic [WIDTH-1:0] sr_data_q, sr_data_d;

    assign rdy_w[SHW] = !sr_valid_q | out_ready;

    // Round stage: a set guard implies a nonzero shift, so no overflow.
    always_comb begin
        sr_valid_d = sr_valid_q;
        sr_data_d  = sr_data_q;
        if (rdy_w[SHW]) begin
            sr_valid_d = v_w[SHW];
            if (v_w[SHW]) begin
                sr_data_d = d_w[SHW]
                          + {{(WIDTH-1){1'b0}}, rn_w[SHW] & g_w[SHW]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_valid_q <= 1'b0;
            sr_data_q  <= '0;
        end else begin
            sr_valid_q <= sr_valid_d;
            sr_data_q  <= sr_data_d;
        end
    end

    assign out_valid = sr_valid_q;
    assign dataout   = sr_data_q;

endmodule

// File: tb/tb_cordic_bshift.sv
// Self-checking bench for cordic_bshift at WIDTH=16.
// Directed edges, backpressure, random throughput and mid-flight reset.
module tb_cordic_bshift;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [3:0]  sh;
    logic        arith;
    logic        rnd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dataout;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [15:0] held = '0;

    always #5 clk = ~clk;

    cordic_bshift #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .sh        (sh),
        .arith     (arith),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout)
    );

    // Reference: floor division by 2^s, plus the bit just below the cut.
    function automatic logic [15:0] model(input logic [15:0] av, input int s,
                                          input logic ar, input logic rn);
        int p;
        int v;
        int q;
        p = 1 << s;
        if (ar) begin
            v = int'($signed(av));
            q = (v >= 0) ? v / p : -((-v + p - 1) / p);
        end else begin
            v = int'(av);
            q = v / p;
        end
        if (rn && s > 0) q = q + ((int'(av) / (p / 2)) % 2);
        return q[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, account transfers.
    task automatic cycle(input logic v, input logic [15:0] av,
                         input logic [3:0] sv, input logic ar, input logic rn,
                         input logic ordy, output logic pushed,
                         output logic popped, output logic [15:0] pval);
        in_valid  = v;
        a         = av;
        sh        = sv;
        arith     = ar;
        rnd       = rn;
        out_ready = ordy;
        #1;
        if (stall_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(dataout), 32'(held));
        end
        stall_prev = out_valid && !out_ready;
        held       = dataout;
        popped     = out_valid && out_ready;
        pval       = dataout;
        if (popped) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("result", 32'(dataout), 32'(exp_q.pop_front()));
        end
        pushed = in_valid && in_ready;
        if (pushed) exp_q.push_back(model(av, int'(sv), ar, rn));
        @(negedge clk);
    endtask

    task automatic single(input string tag, input logic [15:0] av,
                          input logic [3:0] sv, input logic ar, input logic rn,
                          input logic [15:0] expv);
        logic        pu, po;
        logic [15:0] pv;
        int          lat;
        bit          got;
        lat = 0;
        got = 0;
        cycle(1'b1, av, sv, ar, rn, 1'b1, pu, po, pv);
        check({tag, "_accept"}, 32'(pu), 32'd1);
        for (int i = 1; i <= 10 && !got; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, pu, po, pv);
            if (po) begin
                got = 1;
                lat = i;
                check(tag, 32'(pv), 32'(expv));
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
    endtask

    initial begin
        logic        pu, po;
        logic [15:0] pv;
        logic [15:0] ba[8];
        logic [3:0]  bs[8];
        logic        bar[8];
        logic        brn[8];
        int          acc, pops, drop_at, first_pop, last_pop, gaps, ir_low;
        logic [15:0] ra;
        logic [3:0]  rs;
        logic        rar, rrn, v, ordy;

        reset = 1'b1;
        in_valid = 1'b0;
        a = '0;
        sh = '0;
        arith = 1'b0;
        rnd = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dataout", 32'(dataout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        single("arith_sh2", 16'h8000, 4'd2, 1'b1, 1'b0, 16'hE000);
        single("arith_sh15_pos", 16'h7FFF, 4'd15, 1'b1, 1'b0, 16'h0000);
        single("logic_sh15", 16'h8000, 4'd15, 1'b0, 1'b0, 16'h0001);
        single("sh0", 16'h1234, 4'd0, 1'b0, 1'b0, 16'h1234);
        single("sh0_rnd", 16'hFFFF, 4'd0, 1'b1, 1'b1, 16'hFFFF);
        single("arith_sh15_neg", 16'hFFFF, 4'd15, 1'b1, 1'b0, 16'hFFFF);
        single("rnd_pos", 16'h0007, 4'd1, 1'b0, 1'b1, 16'h0004);
        single("rnd_neg", 16'hFFF9, 4'd1, 1'b1, 1'b1, 16'hFFFD);
        single("rnd_exact", 16'h0004, 4'd2, 1'b0, 1'b1, 16'h0001);

        // Backpressure: out_ready low on cycles 3..9 of an 8-beat stream.
        for (int i = 0; i < 8; i++) begin
            ba[i]  = 16'($urandom);
            bs[i]  = 4'($urandom_range(0, 15));
            bar[i] = 1'($urandom);
            brn[i] = 1'($urandom);
        end
        acc = 0;
        pops = 0;
        drop_at = -1;
        for (int t = 0; t < 40; t++) begin
            ordy = !(t >= 3 && t <= 9);
            v = (acc < 8);
            cycle(v, ba[acc % 8], bs[acc % 8], bar[acc % 8], brn[acc % 8],
                  ordy, pu, po, pv);
            if (v && !pu && drop_at < 0) drop_at = acc;
            if (pu) acc++;
            if (po) pops++;
        end
        check("bp_drop_after", 32'(drop_at), 32'd5);
        check("bp_accepted", 32'(acc), 32'd8);
        check("bp_popped", 32'(pops), 32'd8);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Full throughput with random beats.
        acc = 0;
        pops = 0;
        first_pop = -1;
        last_pop = -1;
        gaps = 0;
        ir_low = 0;
        for (int t = 0; t < 110; t++) begin
            v   = (acc < 100);
            ra  = 16'($urandom);
            rs  = 4'($urandom_range(0, 15));
            rar = 1'($urandom);
            rrn = 1'($urandom);
            cycle(v, ra, rs, rar, rrn, 1'b1, pu, po, pv);
            if (v && !pu) ir_low++;
            if (pu) acc++;
            if (po) begin
                if (first_pop < 0) first_pop = t;
                else if (t != last_pop + 1) gaps++;
                last_pop = t;
                pops++;
            end
        end
        check("tp_first_pop", 32'(first_pop), 32'd5);
        check("tp_popped", 32'(pops), 32'd100);
        check("tp_in_ready_low", 32'(ir_low), 32'd0);
        check("tp_gaps", 32'(gaps), 32'd0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'(16'h1111 * (i + 1)), 4'(i), 1'b0, 1'b0, 1'b1,
                  pu, po, pv);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_dataout", 32'(dataout), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        pops = 0;
        for (int t = 0; t < 8; t++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, pu, po, pv);
            if (po) pops++;
        end
        check("mid_rst_no_ghost", 32'(pops), 32'd0);
        single("post_rst", 16'hC350, 4'd4, 1'b1, 1'b1, 16'hFC35);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_bshift.md
# cordic_bshift

Pipelined, parametrised right barrel shifter for the CORDIC datapath. It generalises the fixed single-distance shift cells into one block that takes a runtime shift amount of 0..WIDTH-1 and supports:
- arithmetic or logical mode;
- optional round-half-up.

Each stage has a valid/ready handshake, so the block slots between the iteration-counter logic and the X/Y adders without global stalls.

## Interface
Parameters:
- WIDTH, 16, data width in bits (≥4).
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, reset synchronous active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand, two's complement in arithmetic mode.
- sh  in  SHW  right-shift distance.
- arith  in  1  1 = sign-fill, 0 = zero-fill.
- rnd  in  1  1 = add the last bit shifted out (round half up).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts.
- dataout  out  WIDTH  shifted (and rounded) result.

## Operation
- Stages S0..S(SHW-1) each hold: valid, data, remaining sh bits, arith, rnd, guard bit g.
  - Stage k shifts right by 2^k when sh[k]=1, using sign fill (arith) or zero fill.
  - When stage k shifts, g ← data[2^k−1] of its input; otherwise g passes through. S0 loads g=0.
- Final stage SR: dataout ← data + (rnd & g), truncated to WIDTH.
  - Overflow is impossible: g=1 implies a nonzero shift, which halves the magnitude.
- Result must equal floor(a / 2^sh) in arithmetic mode or a >> sh in logical mode, plus a[sh−1] when rnd=1 and sh>0.
- Handshake, per stage j (S0..SR), using the elastic bubble-collapse rule:
  - ready_j = !valid_j | ready_{j+1}.
  - ready after SR = out_ready.
  - in_ready = ready_S0.
  - A stage loads on ready_j; its valid becomes the upstream valid.
  - Data registers load only when the upstream valid is high.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- While out_valid=1 and out_ready=0, dataout and out_valid hold stable. No beat is dropped or duplicated.
- Boundaries:
  - sh=0 → dataout=a, g=0.
  - sh=WIDTH-1, arith → all sign bits. sh=WIDTH-1, logical → {0…, a[WIDTH-1]}.
  - Simultaneous output pop and input push on a full pipe → both occur; throughput stays 1 beat/cycle.
  - reset mid-operation → all valids cleared on that edge, in-flight beats discarded.
  - in_ready is 1 on the first cycle after reset deasserts.

## Timing
- Latency: SHW+1 cycles from input transfer to out_valid, with no backpressure (5 cycles at WIDTH=16).
- Throughput: 1 result/cycle with out_ready held high.
- Capacity: SHW+1 beats in flight.
- in_ready is combinational from out_ready, through the ready chain. No other input-to-output combinational path.
- Reset values: out_valid=0, dataout=0, in_ready=1 (follows from all valids=0), all stage registers 0.

## Structure
- Package cordic_pkg:
  - function clog2-derived SHW helper;
  - localparam DEFAULT_WIDTH=16;
  - typedef struct stage_t {data, sh, arith, rnd, g, valid}, parametrised via WIDTH in the module.
- Sub-module cordic_bshift_stage #(WIDTH, DIST):
  - one registered conditional shift-by-DIST with guard update and handshake;
  - instantiated SHW times with DIST=2^k in a generate loop.
- The rounding stage SR lives in the top level.

## Test plan
- Arith, no round: a=0x8000, sh=2, arith=1, rnd=0 → dataout=0xE000 after 5 cycles. a=0x7FFF, sh=15 → 0x0000.
- Logical and edges:
  - a=0x8000, sh=15, arith=0 → 0x0001.
  - sh=0, a=0x1234 → 0x1234.
  - a=0xFFFF, sh=15, arith=1 → 0xFFFF.
- Rounding:
  - a=0x0007, sh=1, rnd=1 → 0x0004.
  - a=0xFFF9 (−7), sh=1, arith=1, rnd=1 → 0xFFFD (−3).
  - a=0x0004, sh=2, rnd=1 → 0x0001.
- Backpressure: stream 8 beats back-to-back with out_ready low for cycles 3–9 → in_ready drops after 5 beats accepted; all 8 results emerge in order, none lost or duplicated; dataout stable while stalled.
- Full throughput: 100 random {a, sh, arith, rnd} beats with out_ready=1 → one result per cycle after 5-cycle fill, all matching the golden model.
- Reset mid-flight: 3 beats in flight, assert reset one cycle → out_valid=0, dataout=0 next cycle; none of the 3 beats appear; the next beat after reset has latency 5.
